// File: rtl/note_sequencer.sv
// note_sequencer: plays a stored melody from a programmable note table and
// drives the one-hot tone-select bus that soundSystem turns into speaker output.
// Each table entry is {note code[7:5], duration in ticks[4:0]}; a duration of
// zero marks the end of the song. An optional silent gap follows every note.
module note_sequencer #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int TICK_HZ   = 100,
   parameter int SEQ_LEN   = 16,
   parameter int GAP_TICKS = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       loop_en,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic [4:0] song,
   output logic       busy,
   output logic [3:0] note_idx,
   output logic       done
);

   // Clock cycles per duration tick, and counter widths derived from it.
   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CNT_W    = (GAP_TICKS > 31) ? $clog2(GAP_TICKS + 1) : 5;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_TICKS);
   localparam logic [3:0]       LAST_IDX = 4'(SEQ_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;

   logic [7:0]       table_mem [SEQ_LEN];

   logic [PRE_W-1:0] presc;
   logic [PRE_W-1:0] presc_nx;
   logic [CNT_W-1:0] ticks_left;
   logic [CNT_W-1:0] ticks_nx;

   logic [4:0]       song_nx;
   logic             busy_nx;
   logic [3:0]       idx_nx;
   logic             done_nx;

   logic             tick;
   logic             at_end;
   logic             advance;
   logic             do_fetch;
   logic [7:0]       fetch_entry;
   logic [3:0]       fetch_idx;
   logic [7:0]       entry0;
   logic [7:0]       entry_next;

   // Note codes 1..5 select one speaker tone; 0, 6 and 7 are rests.
   function automatic logic [4:0] decode_note(input logic [2:0] code);
      logic [4:0] tone;
      case (code)
         3'd1:    tone = 5'b00001;
         3'd2:    tone = 5'b00010;
         3'd3:    tone = 5'b00100;
         3'd4:    tone = 5'b01000;
         3'd5:    tone = 5'b10000;
         default: tone = 5'b00000;
      endcase
      return tone;
   endfunction

   assign entry0     = table_mem[0];
   assign entry_next = table_mem[note_idx + 4'd1];
   assign tick       = (presc == PRE_LAST);
   assign at_end     = (note_idx == LAST_IDX) || (entry_next[4:0] == 5'd0);

   // Note table: cleared to an empty song on reset, written from the host port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SEQ_LEN; i++) begin
            table_mem[i] <= 8'd0;
         end
      end else if (wr_en) begin
         table_mem[wr_addr] <= wr_data;
      end
   end

   // Next-state and next-output logic; every transition restarts the prescaler.
   always_comb begin
      state_nx    = state;
      song_nx     = song;
      busy_nx     = busy;
      idx_nx      = note_idx;
      done_nx     = 1'b0;
      ticks_nx    = ticks_left;
      presc_nx    = tick ? '0 : presc + PRE_W'(1);
      advance     = 1'b0;
      do_fetch    = 1'b0;
      fetch_entry = entry0;
      fetch_idx   = 4'd0;

      case (state)
         IDLE: begin
            presc_nx = '0;
            if (start) begin
               if (entry0[4:0] != 5'd0) begin
                  do_fetch = 1'b1;
               end else begin
                  done_nx = 1'b1;
               end
            end
         end
         PLAY: begin
            if (tick) begin
               if (ticks_left == CNT_W'(1)) begin
                  if (GAP_TICKS > 0) begin
                     state_nx = GAP;
                     song_nx  = 5'd0;
                     ticks_nx = GAP_LOAD;
                     presc_nx = '0;
                  end else begin
                     advance = 1'b1;
                  end
               end else begin
                  ticks_nx = ticks_left - CNT_W'(1);
               end
            end
         end
         GAP: begin
            if (tick) begin
               if (ticks_left == CNT_W'(1)) begin
                  advance = 1'b1;
               end else begin
                  ticks_nx = ticks_left - CNT_W'(1);
               end
            end
         end
         default: begin
            state_nx = IDLE;
            song_nx  = 5'd0;
            busy_nx  = 1'b0;
            presc_nx = '0;
         end
      endcase

      if (advance) begin
         if (at_end) begin
            if (loop_en && (entry0[4:0] != 5'd0)) begin
               do_fetch = 1'b1;
            end else begin
               state_nx = IDLE;
               song_nx  = 5'd0;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
               presc_nx = '0;
            end
         end else begin
            do_fetch    = 1'b1;
            fetch_entry = entry_next;
            fetch_idx   = note_idx + 4'd1;
         end
      end

      if (do_fetch) begin
         state_nx = PLAY;
         idx_nx   = fetch_idx;
         song_nx  = decode_note(fetch_entry[7:5]);
         busy_nx  = 1'b1;
         ticks_nx = CNT_W'(fetch_entry[4:0]);
         presc_nx = '0;
      end

      if (stop) begin
         state_nx = IDLE;
         song_nx  = 5'd0;
         busy_nx  = 1'b0;
         done_nx  = 1'b0;
         presc_nx = '0;
      end
   end

   // State, timing counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         presc      <= '0;
         ticks_left <= '0;
         song       <= 5'd0;
         busy       <= 1'b0;
         note_idx   <= 4'd0;
         done       <= 1'b0;
      end else begin
         state      <= state_nx;
         presc      <= presc_nx;
         ticks_left <= ticks_nx;
         song       <= song_nx;
         busy       <= busy_nx;
         note_idx   <= idx_nx;
         done       <= done_nx;
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: scoreboard bench for note_sequencer. Unit A has a two-tick
// gap and no looping; unit B is legato and loops. Expected per-cycle outputs
// are built from the bench's own copy of the note table.
module tb_note_sequencer;

   localparam int TICK_DIV = 10;
   localparam int GAP_A    = 2;
   localparam int GAP_B    = 0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start_a = 1'b0;
   logic       stop_a = 1'b0;
   logic       loop_a = 1'b0;
   logic       start_b = 1'b0;
   logic       stop_b = 1'b0;
   logic       loop_b = 1'b1;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = 4'd0;
   logic [7:0] wr_data = 8'd0;

   logic [4:0] song_a;
   logic       busy_a;
   logic [3:0] idx_a;
   logic       done_a;
   logic [4:0] song_b;
   logic       busy_b;
   logic [3:0] idx_b;
   logic       done_b;

   typedef struct {
      int         sel;
      logic [4:0] song;
      logic       busy;
      logic       done;
      logic [3:0] idx;
      bit         chk;
      string      tag;
   } exp_t;

   exp_t       scoreQ [$];
   exp_t       monItem;
   int         nCompared = 0;
   int         nMismatched = 0;
   logic [7:0] tbTable [16];
   logic [4:0] toneOf [8];

   note_sequencer #(
      .CLK_HZ(1000), .TICK_HZ(100), .SEQ_LEN(16), .GAP_TICKS(GAP_A)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a),
      .loop_en(loop_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .song(song_a), .busy(busy_a), .note_idx(idx_a), .done(done_a)
   );

   note_sequencer #(
      .CLK_HZ(1000), .TICK_HZ(100), .SEQ_LEN(16), .GAP_TICKS(GAP_B)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b),
      .loop_en(loop_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .song(song_b), .busy(busy_b), .note_idx(idx_b), .done(done_b)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   function automatic logic [31:0] packOut(input logic [4:0] s, input logic b,
                                           input logic d, input logic [3:0] i);
      return {21'd0, s, b, d, i};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input int sel, input logic st, input logic sp);
      if (sel == 0) begin
         start_a = st;
         stop_a  = sp;
      end else begin
         start_b = st;
         stop_b  = sp;
      end
   endtask

   task automatic stepCycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pushItem(input int sel, input logic [4:0] s, input logic b,
                           input logic d, input logic [3:0] i, input bit chk,
                           input string tag);
      exp_t it;
      it.sel  = sel;
      it.song = s;
      it.busy = b;
      it.done = d;
      it.idx  = i;
      it.chk  = chk;
      it.tag  = tag;
      scoreQ.push_back(it);
   endtask

   // Expected stream for one playback: first item is the cycle before start is sampled.
   task automatic pushSong(input int sel, input int gap, input bit loopOn,
                           input int maxItems, input string tag);
      int         n;
      int         i;
      bit         fin;
      logic [4:0] tone;
      int         dur;
      n   = 1;
      i   = 0;
      fin = 1'b0;
      pushItem(sel, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, tag);
      while (!fin && n < maxItems) begin
         if (i < 16 && tbTable[i][4:0] != 5'd0) begin
            dur  = int'(tbTable[i][4:0]);
            tone = toneOf[tbTable[i][7:5]];
            for (int c = 0; c < dur * TICK_DIV && n < maxItems; c++) begin
               pushItem(sel, tone, 1'b1, 1'b0, 4'(i), 1'b1, tag);
               n++;
            end
            for (int c = 0; c < gap * TICK_DIV && n < maxItems; c++) begin
               pushItem(sel, 5'd0, 1'b1, 1'b0, 4'(i), 1'b1, tag);
               n++;
            end
            i++;
         end else if (loopOn && tbTable[0][4:0] != 5'd0) begin
            i = 0;
         end else begin
            pushItem(sel, 5'd0, 1'b0, 1'b1, 4'd0, 1'b0, {tag, "_done"});
            pushItem(sel, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, {tag, "_after"});
            fin = 1'b1;
         end
      end
   endtask

   task automatic drain(input int maxCycles, input string tag);
      int n;
      n = 0;
      while (scoreQ.size() != 0 && n < maxCycles) begin
         @(posedge clk);
         n++;
      end
      #2;
      if (scoreQ.size() != 0) begin
         checkOutput({tag, "_timeout"}, 32'(scoreQ.size()), 32'd0);
         scoreQ.delete();
      end
   endtask

   task automatic writeEntry(input int addr, input logic [2:0] code, input logic [4:0] dur);
      wr_en         = 1'b1;
      wr_addr       = 4'(addr);
      wr_data       = {code, dur};
      tbTable[addr] = {code, dur};
      stepCycles(1);
      wr_en         = 1'b0;
   endtask

   task automatic clearTable();
      for (int i = 0; i < 16; i++) tbTable[i] = 8'd0;
   endtask

   task automatic playSong(input int sel, input int gap, input string tag);
      applyStimulus(sel, 1'b1, 1'b0);
      pushSong(sel, gap, 1'b0, 100000, tag);
      stepCycles(1);
      applyStimulus(sel, 1'b0, 1'b0);
      drain(2000, tag);
   endtask

   // Scoreboard consumer: compare the oldest expectation against the addressed unit.
   always @(negedge clk) begin
      if (scoreQ.size() > 0) begin
         monItem = scoreQ.pop_front();
         if (monItem.sel == 0) begin
            checkOutput(monItem.tag,
                        packOut(song_a, busy_a, done_a, monItem.chk ? idx_a : 4'd0),
                        packOut(monItem.song, monItem.busy, monItem.done,
                                monItem.chk ? monItem.idx : 4'd0));
         end else begin
            checkOutput(monItem.tag,
                        packOut(song_b, busy_b, done_b, monItem.chk ? idx_b : 4'd0),
                        packOut(monItem.song, monItem.busy, monItem.done,
                                monItem.chk ? monItem.idx : 4'd0));
         end
      end
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: run still active at %0t, limit 200000", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      toneOf = '{5'b00000, 5'b00001, 5'b00010, 5'b00100,
                 5'b01000, 5'b10000, 5'b00000, 5'b00000};
      clearTable();

      #1 rst_n = 1'b0;
      #2;
      checkOutput("reset_a", packOut(song_a, busy_a, done_a, idx_a), 32'd0);
      checkOutput("reset_b", packOut(song_b, busy_b, done_b, idx_b), 32'd0);
      stepCycles(2);
      rst_n = 1'b1;
      stepCycles(1);

      $display("[TB] empty table start");
      playSong(0, GAP_A, "t4_empty");

      writeEntry(0, 3'd1, 5'd3);
      writeEntry(1, 3'd3, 5'd1);
      writeEntry(2, 3'd0, 5'd0);

      $display("[TB] two notes with gap");
      playSong(0, GAP_A, "t1_gap");

      $display("[TB] legato loop then stop");
      applyStimulus(1, 1'b1, 1'b0);
      pushSong(1, GAP_B, 1'b1, 81, "t2_loop");
      pushItem(1, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, "t2_stop");
      pushItem(1, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, "t2_stop");
      stepCycles(1);
      applyStimulus(1, 1'b0, 1'b0);
      stepCycles(79);
      applyStimulus(1, 1'b0, 1'b1);
      stepCycles(1);
      applyStimulus(1, 1'b0, 1'b0);
      drain(200, "t2");

      $display("[TB] stop mid note then replay");
      applyStimulus(0, 1'b1, 1'b0);
      pushSong(0, GAP_A, 1'b0, 16, "t3_note0");
      pushItem(0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, "t3_stop");
      pushItem(0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, "t3_stop");
      stepCycles(1);
      applyStimulus(0, 1'b0, 1'b0);
      stepCycles(14);
      applyStimulus(0, 1'b0, 1'b1);
      stepCycles(1);
      applyStimulus(0, 1'b0, 1'b0);
      drain(50, "t3");
      playSong(0, GAP_A, "t3_replay");

      $display("[TB] full sixteen entry table");
      for (int i = 0; i < 16; i++) writeEntry(i, 3'd5, 5'd1);
      playSong(0, GAP_A, "t5_full");

      $display("[TB] reset mid song");
      applyStimulus(0, 1'b1, 1'b0);
      pushSong(0, GAP_A, 1'b0, 65, "t5_mid");
      stepCycles(1);
      applyStimulus(0, 1'b0, 1'b0);
      drain(200, "t5_mid");
      rst_n = 1'b0;
      #1;
      checkOutput("t5_rst_a", packOut(song_a, busy_a, done_a, idx_a), 32'd0);
      checkOutput("t5_rst_b", packOut(song_b, busy_b, done_b, idx_b), 32'd0);
      clearTable();
      stepCycles(1);
      rst_n = 1'b1;
      stepCycles(1);
      playSong(0, GAP_A, "t5_cleared");

      $display("[TB] rest entry and start held");
      writeEntry(0, 3'd1, 5'd1);
      writeEntry(1, 3'd0, 5'd2);
      writeEntry(2, 3'd2, 5'd1);
      writeEntry(3, 3'd0, 5'd0);
      applyStimulus(0, 1'b1, 1'b0);
      pushSong(0, GAP_A, 1'b0, 100000, "t6_rest");
      stepCycles(50);
      applyStimulus(0, 1'b0, 1'b0);
      drain(300, "t6_rest");

      $display("[TB] stop and start together");
      applyStimulus(0, 1'b1, 1'b0);
      pushSong(0, GAP_A, 1'b0, 6, "t6_play");
      stepCycles(1);
      applyStimulus(0, 1'b0, 1'b0);
      stepCycles(4);
      applyStimulus(0, 1'b1, 1'b1);
      pushItem(0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, "t6_both");
      pushItem(0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, "t6_both");
      stepCycles(1);
      applyStimulus(0, 1'b0, 1'b0);
      drain(50, "t6_both");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
